// File: rtl/axi_cdma_arb_pkg.sv
// Shared helpers for the CDMA descriptor arbiter: port-index decode,
// {port, tag} packing and status_error cause bits.
package axi_cdma_arb_pkg;

    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_BAD_PORT  = 2'b10;

    function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

    function automatic logic [31:0] tag_pack(input logic [31:0] port, input logic [31:0] tag,
                                             input int s_w);
        return (port << s_w) | tag;
    endfunction

    function automatic logic [31:0] tag_port(input logic [31:0] mtag, input int s_w);
        return mtag >> s_w;
    endfunction

    function automatic logic [31:0] tag_local(input logic [31:0] mtag, input int s_w);
        return mtag & ((32'd1 << s_w) - 32'd1);
    endfunction

endpackage

// File: rtl/axi_cdma_desc_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last winner.
module rr_arbiter #(
    parameter int PORTS    = 4,
    parameter int CL_PORTS = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [PORTS-1:0] req,
    output logic [PORTS-1:0] grant
);

    logic [CL_PORTS-1:0] ptr_q, ptr_d;
    logic [CL_PORTS-1:0] idx;
    logic                found;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        if (enable) begin
            for (int k = 1; k <= PORTS; k++) begin
                idx = CL_PORTS'((int'(ptr_q) + k) % PORTS);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d      = idx;
                end
            end
        end
    end

    // Pointer resets to the last port so port 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= CL_PORTS'(PORTS - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_cdma_desc_arb.sv
// Round-robin descriptor arbiter sharing one CDMA between PORTS requesters.
// Optional macro AXI_CDMA_DESC_ARB_ZERO_LEN_EN completes len==0 descriptors locally.
module axi_cdma_desc_arb
    import axi_cdma_arb_pkg::*;
#(
    parameter int PORTS           = 4,
    parameter int ADDR_WIDTH      = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int S_TAG_WIDTH     = 8,
    parameter int CL_PORTS        = $clog2(PORTS),
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PORTS*ADDR_WIDTH-1:0]      s_axis_desc_read_addr,
    input  logic [PORTS*ADDR_WIDTH-1:0]      s_axis_desc_write_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]       s_axis_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_desc_tag,
    input  logic [PORTS-1:0]                 s_axis_desc_valid,
    output logic [PORTS-1:0]                 s_axis_desc_ready,
    output logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_desc_status_tag,
    output logic [PORTS-1:0]                 s_axis_desc_status_valid,
    output logic [ADDR_WIDTH-1:0]            m_axis_desc_read_addr,
    output logic [ADDR_WIDTH-1:0]            m_axis_desc_write_addr,
    output logic [LEN_WIDTH-1:0]             m_axis_desc_len,
    output logic [M_TAG_WIDTH-1:0]           m_axis_desc_tag,
    output logic                             m_axis_desc_valid,
    input  logic                             m_axis_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]           m_axis_desc_status_tag,
    input  logic                             m_axis_desc_status_valid,
    input  logic                             enable,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                             idle,
    output logic                             status_error
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [PORTS-1:0]             req, grant;
    logic                         can_load, gnt_vld, zl_take, load, issue;
    logic [31:0]                  gnt_idx, st_port;
    logic [ADDR_WIDTH-1:0]        sel_rd, sel_wr;
    logic [LEN_WIDTH-1:0]         sel_len;
    logic [S_TAG_WIDTH-1:0]       sel_tag, st_tag;
    logic [1:0]                   err_cause;

    logic                         m_valid_q, m_valid_d;
    logic [ADDR_WIDTH-1:0]        m_rd_q, m_rd_d, m_wr_q, m_wr_d;
    logic [LEN_WIDTH-1:0]         m_len_q, m_len_d;
    logic [M_TAG_WIDTH-1:0]       m_tag_q, m_tag_d;
    logic [OW-1:0]                out_q, out_d;
    logic [PORTS-1:0]             st_valid_q, st_valid_d;
    logic [PORTS*S_TAG_WIDTH-1:0] st_tag_q, st_tag_d;
    logic                         err_q, err_d;
    logic                         idle_q, idle_d;
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
    logic                         pend_vld_q, pend_vld_d;
    logic [CL_PORTS-1:0]          pend_port_q, pend_port_d;
    logic [S_TAG_WIDTH-1:0]       pend_tag_q, pend_tag_d;
`endif

    // The held descriptor counts against the limit before it is accepted.
    always_comb begin
        can_load = (!m_valid_q || m_axis_desc_ready) && enable
                   && ((int'(out_q) + int'(m_valid_q)) < MAX_OUTSTANDING);
        req = s_axis_desc_valid;
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
        for (int i = 0; i < PORTS; i++) begin
            if (pend_vld_q && s_axis_desc_len[i*LEN_WIDTH +: LEN_WIDTH] == '0) req[i] = 1'b0;
        end
`endif
    end

    rr_arbiter #(
        .PORTS    (PORTS),
        .CL_PORTS (CL_PORTS)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (can_load),
        .req    (req),
        .grant  (grant)
    );

    assign s_axis_desc_ready = grant;

    always_comb begin
        sel_rd  = '0;
        sel_wr  = '0;
        sel_len = '0;
        sel_tag = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                sel_rd  = s_axis_desc_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wr  = s_axis_desc_write_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len = s_axis_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
                sel_tag = s_axis_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH];
            end
        end
        gnt_vld = |grant;
        gnt_idx = onehot_to_idx(32'(grant));
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
        zl_take = gnt_vld && (sel_len == '0);
`else
        zl_take = 1'b0;
`endif
        load  = gnt_vld && !zl_take;
        issue = m_valid_q && m_axis_desc_ready;
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_rd_d    = m_rd_q;
        m_wr_d    = m_wr_q;
        m_len_d   = m_len_q;
        m_tag_d   = m_tag_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_rd_d    = sel_rd;
            m_wr_d    = sel_wr;
            m_len_d   = sel_len;
            m_tag_d   = M_TAG_WIDTH'(tag_pack(gnt_idx, 32'(sel_tag), S_TAG_WIDTH));
        end else if (m_axis_desc_ready) begin
            m_valid_d = 1'b0;
        end

        err_cause = '0;
        out_d     = out_q;
        if (issue && !m_axis_desc_status_valid) begin
            out_d = out_q + OW'(1);
        end else if (!issue && m_axis_desc_status_valid) begin
            if (out_q == '0) err_cause = err_cause | ERR_UNDERFLOW;
            else             out_d = out_q - OW'(1);
        end

        // CDMA status has priority; a local zero-length completion waits for a free cycle.
        st_port    = tag_port(32'(m_axis_desc_status_tag), S_TAG_WIDTH);
        st_tag     = S_TAG_WIDTH'(tag_local(32'(m_axis_desc_status_tag), S_TAG_WIDTH));
        st_valid_d = '0;
        st_tag_d   = st_tag_q;
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
        pend_vld_d  = pend_vld_q;
        pend_port_d = pend_port_q;
        pend_tag_d  = pend_tag_q;
`endif
        if (m_axis_desc_status_valid) begin
            if (st_port >= 32'(PORTS)) err_cause = err_cause | ERR_BAD_PORT;
            for (int i = 0; i < PORTS; i++) begin
                if (st_port == 32'(i)) begin
                    st_valid_d[i]                        = 1'b1;
                    st_tag_d[i*S_TAG_WIDTH +: S_TAG_WIDTH] = st_tag;
                end
            end
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
        end else if (pend_vld_q) begin
            pend_vld_d = 1'b0;
            for (int i = 0; i < PORTS; i++) begin
                if (32'(pend_port_q) == 32'(i)) begin
                    st_valid_d[i]                        = 1'b1;
                    st_tag_d[i*S_TAG_WIDTH +: S_TAG_WIDTH] = pend_tag_q;
                end
            end
`endif
        end
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
        if (zl_take) begin
            pend_vld_d  = 1'b1;
            pend_port_d = CL_PORTS'(gnt_idx);
            pend_tag_d  = sel_tag;
        end
`endif
        err_d  = err_q | (|err_cause);
        idle_d = !m_valid_d && (out_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            m_rd_q     <= '0;
            m_wr_q     <= '0;
            m_len_q    <= '0;
            m_tag_q    <= '0;
            out_q      <= '0;
            st_valid_q <= '0;
            st_tag_q   <= '0;
            err_q      <= 1'b0;
            idle_q     <= 1'b1;
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
            pend_vld_q  <= 1'b0;
            pend_port_q <= '0;
            pend_tag_q  <= '0;
`endif
        end else begin
            m_valid_q  <= m_valid_d;
            m_rd_q     <= m_rd_d;
            m_wr_q     <= m_wr_d;
            m_len_q    <= m_len_d;
            m_tag_q    <= m_tag_d;
            out_q      <= out_d;
            st_valid_q <= st_valid_d;
            st_tag_q   <= st_tag_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
            pend_vld_q  <= pend_vld_d;
            pend_port_q <= pend_port_d;
            pend_tag_q  <= pend_tag_d;
`endif
        end
    end

    assign m_axis_desc_valid        = m_valid_q;
    assign m_axis_desc_read_addr    = m_rd_q;
    assign m_axis_desc_write_addr   = m_wr_q;
    assign m_axis_desc_len          = m_len_q;
    assign m_axis_desc_tag          = m_tag_q;
    assign outstanding              = out_q;
    assign s_axis_desc_status_valid = st_valid_q;
    assign s_axis_desc_status_tag   = st_tag_q;
    assign status_error             = err_q;
    assign idle                     = idle_q;

endmodule

// File: tb/tb_axi_cdma_desc_arb.sv
// Bench for axi_cdma_desc_arb: directed vector table, hand sequences, randomized model check.
module tb_axi_cdma_desc_arb;

    localparam int PORTS = 4;
    localparam int AW    = 16;
    localparam int LW    = 20;
    localparam int SW    = 8;
    localparam int MW    = 10;
    localparam int MAXO  = 8;
    localparam int OW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [PORTS*AW-1:0] rd_bus, wr_bus;
    logic [PORTS*LW-1:0] len_bus;
    logic [PORTS*SW-1:0] tag_bus;
    logic [PORTS-1:0]    s_vld, s_rdy, st_vld;
    logic [PORTS*SW-1:0] st_tag;
    logic [AW-1:0]       m_rd, m_wr;
    logic [LW-1:0]       m_len;
    logic [MW-1:0]       m_tag, c_tag;
    logic                m_vld, m_rdy, c_vld, en, idle, serr;
    logic [OW-1:0]       outs;

    logic [AW-1:0] p_rd [PORTS];
    logic [AW-1:0] p_wr [PORTS];
    logic [LW-1:0] p_len[PORTS];
    logic [SW-1:0] p_tag[PORTS];

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            rd_bus[i*AW +: AW]  = p_rd[i];
            wr_bus[i*AW +: AW]  = p_wr[i];
            len_bus[i*LW +: LW] = p_len[i];
            tag_bus[i*SW +: SW] = p_tag[i];
        end
    end

    always #5 clk = ~clk;

    axi_cdma_desc_arb #(
        .PORTS(PORTS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .S_TAG_WIDTH(SW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .s_axis_desc_read_addr    (rd_bus),
        .s_axis_desc_write_addr   (wr_bus),
        .s_axis_desc_len          (len_bus),
        .s_axis_desc_tag          (tag_bus),
        .s_axis_desc_valid        (s_vld),
        .s_axis_desc_ready        (s_rdy),
        .s_axis_desc_status_tag   (st_tag),
        .s_axis_desc_status_valid (st_vld),
        .m_axis_desc_read_addr    (m_rd),
        .m_axis_desc_write_addr   (m_wr),
        .m_axis_desc_len          (m_len),
        .m_axis_desc_tag          (m_tag),
        .m_axis_desc_valid        (m_vld),
        .m_axis_desc_ready        (m_rdy),
        .m_axis_desc_status_tag   (c_tag),
        .m_axis_desc_status_valid (c_vld),
        .enable                   (en),
        .outstanding              (outs),
        .idle                     (idle),
        .status_error             (serr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic       en;
        logic       sv;
        logic [9:0] stag;
        logic [3:0] e_srdy;
        logic       e_mvld;
        logic [9:0] e_mtag;
        logic [3:0] e_out;
        logic       e_idle;
        logic [3:0] e_svld;
        logic       e_err;
    } vec_t;

    vec_t tbl[19];

    task automatic set_default_payload();
        for (int i = 0; i < PORTS; i++) begin
            p_rd[i]  = 16'h1000 + 16'(i * 16'h100);
            p_wr[i]  = 16'h2000 + 16'(i * 16'h100);
            p_len[i] = 20'd64;
            p_tag[i] = 8'h60 + 8'(i);
        end
        p_tag[0] = 8'h5A;
    endtask

    task automatic do_reset();
        s_vld = '0; m_rdy = 1'b0; en = 1'b0; c_vld = 1'b0; c_tag = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outstanding", 32'(outs), 32'd0);
        chk("rst_m_valid", 32'(m_vld), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_status_error", 32'(serr), 32'd0);
        chk("rst_status_valid", 32'(st_vld), 32'd0);
        rst_n = 1'b1;
        #1;
    endtask

    int          acc, port, gp, k, p;
    bit          can, found;
    int          m_last, m_out;
    bit          m_held;
    logic [9:0]  m_mtag;
    logic [15:0] m_mrd, m_mwr;
    logic [19:0] m_mlen;
    logic [3:0]  e_sv, exp_rdy;
    logic [7:0]  e_stag[PORTS];
    logic [9:0]  infl[$];

    initial begin
        set_default_payload();
        //              vld    rdy   en    sv    stag      srdy   mvld  mtag      out  idle  svld   err
        tbl[0]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 10'h000, 4'b0001, 1'b1, 10'h05A, 4'd0, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 10'h000, 4'b0000, 1'b0, 10'h05A, 4'd1, 1'b0, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h05A, 4'b0000, 1'b0, 10'h05A, 4'd0, 1'b1, 4'b0001, 1'b0};
        tbl[3]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 10'h000, 4'b0000, 1'b0, 10'h05A, 4'd0, 1'b1, 4'b0000, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 10'h000, 4'b0010, 1'b1, 10'h161, 4'd0, 1'b0, 4'b0000, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 10'h000, 4'b0100, 1'b1, 10'h262, 4'd1, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 10'h000, 4'b1000, 1'b1, 10'h363, 4'd2, 1'b0, 4'b0000, 1'b0};
        tbl[7]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 10'h000, 4'b0001, 1'b1, 10'h05A, 4'd3, 1'b0, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h161, 4'b0000, 1'b0, 10'h05A, 4'd3, 1'b0, 4'b0010, 1'b0};
        tbl[9]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 10'h000, 4'b0100, 1'b1, 10'h262, 4'd3, 1'b0, 4'b0000, 1'b0};
        tbl[10] = '{4'b1111, 1'b0, 1'b0, 1'b0, 10'h000, 4'b0000, 1'b1, 10'h262, 4'd3, 1'b0, 4'b0000, 1'b0};
        tbl[11] = '{4'b1111, 1'b1, 1'b0, 1'b0, 10'h000, 4'b0000, 1'b0, 10'h262, 4'd4, 1'b0, 4'b0000, 1'b0};
        tbl[12] = '{4'b1000, 1'b0, 1'b1, 1'b0, 10'h000, 4'b1000, 1'b1, 10'h363, 4'd4, 1'b0, 4'b0000, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h262, 4'b0000, 1'b0, 10'h363, 4'd4, 1'b0, 4'b0100, 1'b0};
        tbl[14] = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h05A, 4'b0000, 1'b0, 10'h363, 4'd3, 1'b0, 4'b0001, 1'b0};
        tbl[15] = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h363, 4'b0000, 1'b0, 10'h363, 4'd2, 1'b0, 4'b1000, 1'b0};
        tbl[16] = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h262, 4'b0000, 1'b0, 10'h363, 4'd1, 1'b0, 4'b0100, 1'b0};
        tbl[17] = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h363, 4'b0000, 1'b0, 10'h363, 4'd0, 1'b1, 4'b1000, 1'b0};
        tbl[18] = '{4'b0000, 1'b1, 1'b1, 1'b1, 10'h161, 4'b0000, 1'b0, 10'h363, 4'd0, 1'b1, 4'b0010, 1'b1};

        do_reset();

        for (int i = 0; i < 19; i++) begin
            s_vld = tbl[i].vld; m_rdy = tbl[i].rdy; en = tbl[i].en;
            c_vld = tbl[i].sv;  c_tag = tbl[i].stag;
            #1;
            chk($sformatf("v%0d_s_ready", i), 32'(s_rdy), 32'(tbl[i].e_srdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_m_valid", i), 32'(m_vld), 32'(tbl[i].e_mvld));
            if (tbl[i].e_mvld) begin
                port = int'(tbl[i].e_mtag[9:8]);
                chk($sformatf("v%0d_m_tag", i), 32'(m_tag), 32'(tbl[i].e_mtag));
                chk($sformatf("v%0d_m_rd", i), 32'(m_rd), 32'(p_rd[port]));
                chk($sformatf("v%0d_m_wr", i), 32'(m_wr), 32'(p_wr[port]));
                chk($sformatf("v%0d_m_len", i), 32'(m_len), 32'(p_len[port]));
            end
            chk($sformatf("v%0d_outstanding", i), 32'(outs), 32'(tbl[i].e_out));
            chk($sformatf("v%0d_idle", i), 32'(idle), 32'(tbl[i].e_idle));
            chk($sformatf("v%0d_status_valid", i), 32'(st_vld), 32'(tbl[i].e_svld));
            chk($sformatf("v%0d_status_error", i), 32'(serr), 32'(tbl[i].e_err));
            for (int q = 0; q < PORTS; q++) begin
                if (tbl[i].e_svld[q])
                    chk($sformatf("v%0d_status_tag%0d", i, q), 32'(st_tag[q*SW +: SW]),
                        32'(tbl[i].stag[7:0]));
            end
        end
        c_vld = 1'b0;

        // Outstanding limit: exactly MAXO accepted with no status returned.
        do_reset();
        s_vld = '1; m_rdy = 1'b1; en = 1'b1;
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            #1; acc += $countones(s_rdy);
            @(posedge clk); #1;
        end
        chk("max_accepted", 32'(acc), 32'(MAXO));
        chk("max_outstanding", 32'(outs), 32'(MAXO));
        chk("max_no_ready", 32'(s_rdy), 32'd0);
        c_vld = 1'b1; c_tag = 10'h05A;
        #1;
        chk("max_status_cycle_ready", 32'(s_rdy), 32'd0);
        @(posedge clk); #1;
        c_vld = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1; acc += $countones(s_rdy);
            @(posedge clk); #1;
        end
        chk("max_one_more", 32'(acc), 32'd1);
        chk("max_outstanding_again", 32'(outs), 32'(MAXO));

        // Asynchronous reset mid-operation, then a stale status.
        rst_n = 1'b0;
        #1;
        chk("midrst_outstanding", 32'(outs), 32'd0);
        chk("midrst_m_valid", 32'(m_vld), 32'd0);
        chk("midrst_idle", 32'(idle), 32'd1);
        s_vld = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        c_vld = 1'b1; c_tag = 10'h161;
        @(posedge clk); #1;
        c_vld = 1'b0;
        chk("stale_status_error", 32'(serr), 32'd1);
        chk("stale_outstanding", 32'(outs), 32'd0);
        chk("stale_status_routed", 32'(st_vld), 32'b0010);
        chk("stale_status_tag", 32'(st_tag[1*SW +: SW]), 32'h61);

`ifdef AXI_CDMA_DESC_ARB_ZERO_LEN_EN
        do_reset();
        p_len[2] = '0; p_tag[2] = 8'h11;
        s_vld = 4'b0100; en = 1'b1; m_rdy = 1'b0;
        #1;
        chk("zl_s_ready", 32'(s_rdy), 32'b0100);
        @(posedge clk); #1;
        s_vld = '0;
        chk("zl_no_m_valid", 32'(m_vld), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (!found && st_vld[2]) begin
                found = 1'b1;
                chk("zl_status_tag", 32'(st_tag[2*SW +: SW]), 32'h11);
            end
            chk("zl_outstanding", 32'(outs), 32'd0);
            if (!found) begin @(posedge clk); #1; end
        end
        chk("zl_status_seen", 32'(found), 32'd1);
        chk("zl_no_m_valid_after", 32'(m_vld), 32'd0);
        set_default_payload();
`endif

        // Randomized traffic against a transaction-level reference model.
        do_reset();
        m_last = PORTS - 1; m_out = 0; m_held = 1'b0; m_mtag = '0;
        m_mrd = '0; m_mwr = '0; m_mlen = '0;
        for (int i = 0; i < PORTS; i++) e_stag[i] = '0;
        infl.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_vld = 4'($urandom);
            for (int i = 0; i < PORTS; i++) begin
                p_rd[i]  = 16'($urandom);
                p_wr[i]  = 16'($urandom);
                p_len[i] = 20'($urandom_range(1, 4096));
                p_tag[i] = 8'($urandom);
            end
            m_rdy = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 7) != 0);
            c_vld = 1'b0;
            if (infl.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, infl.size() - 1));
                c_vld = 1'b1; c_tag = infl[k];
                infl.delete(k);
            end
            #1;
            can = (!m_held || m_rdy) && en && ((m_out + int'(m_held)) < MAXO);
            gp = -1;
            if (can) begin
                for (int j = 1; j <= PORTS; j++) begin
                    p = (m_last + j) % PORTS;
                    if (gp < 0 && s_vld[p]) gp = p;
                end
            end
            exp_rdy = (gp >= 0) ? 4'(1 << gp) : 4'b0000;
            chk("rand_s_ready", 32'(s_rdy), 32'(exp_rdy));

            if (m_held && m_rdy) begin m_out++; infl.push_back(m_mtag); end
            e_sv = '0;
            if (c_vld) begin
                m_out--;
                e_sv[c_tag[9:8]]   = 1'b1;
                e_stag[c_tag[9:8]] = c_tag[7:0];
            end
            if (gp >= 0) begin
                m_held = 1'b1; m_last = gp;
                m_mtag = {2'(gp), p_tag[gp]};
                m_mrd = p_rd[gp]; m_mwr = p_wr[gp]; m_mlen = p_len[gp];
            end else if (m_rdy) begin
                m_held = 1'b0;
            end

            @(posedge clk); #1;
            chk("rand_m_valid", 32'(m_vld), 32'(m_held));
            if (m_held) begin
                chk("rand_m_tag", 32'(m_tag), 32'(m_mtag));
                chk("rand_m_rd", 32'(m_rd), 32'(m_mrd));
                chk("rand_m_wr", 32'(m_wr), 32'(m_mwr));
                chk("rand_m_len", 32'(m_len), 32'(m_mlen));
            end
            chk("rand_outstanding", 32'(outs), 32'(m_out));
            chk("rand_idle", 32'(idle), 32'(!m_held && m_out == 0));
            chk("rand_status_valid", 32'(st_vld), 32'(e_sv));
            for (int q = 0; q < PORTS; q++)
                chk("rand_status_tag", 32'(st_tag[q*SW +: SW]), 32'(e_stag[q]));
            chk("rand_status_error", 32'(serr), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_cdma_desc_arb.md
Name: axi_cdma_desc_arb

Overview:
- Round-robin descriptor arbiter that shares one axi_cdma instance between PORTS independent requesters.
- Each requester presents a read_addr/write_addr/len/tag descriptor. The winner is forwarded to the CDMA descriptor input with its port index prepended to the tag.
- Returning CDMA status is demultiplexed back to the originating port by the tag's upper bits.
- An outstanding-transfer counter throttles issue so in-flight descriptors never exceed MAX_OUTSTANDING.

Parameters:
PORTS, 4, number of requesters (2..16)
ADDR_WIDTH, 16, descriptor address width (matches CDMA AXI_ADDR_WIDTH)
LEN_WIDTH, 20, descriptor length width
S_TAG_WIDTH, 8, per-port tag width
CL_PORTS, $clog2(PORTS), derived, port index width
M_TAG_WIDTH, S_TAG_WIDTH+CL_PORTS, derived, CDMA-side tag width
MAX_OUTSTANDING, 8, max descriptors issued without status returned (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
s_axis_desc_read_addr  in  PORTS*ADDR_WIDTH  per-port source address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
s_axis_desc_write_addr  in  PORTS*ADDR_WIDTH  per-port destination address
s_axis_desc_len  in  PORTS*LEN_WIDTH  per-port byte length
s_axis_desc_tag  in  PORTS*S_TAG_WIDTH  per-port tag
s_axis_desc_valid  in  PORTS  per-port descriptor valid
s_axis_desc_ready  out  PORTS  per-port accept (one-hot or zero)
s_axis_desc_status_tag  out  PORTS*S_TAG_WIDTH  per-port completion tag
s_axis_desc_status_valid  out  PORTS  per-port completion strobe
m_axis_desc_read_addr  out  ADDR_WIDTH  to CDMA
m_axis_desc_write_addr  out  ADDR_WIDTH  to CDMA
m_axis_desc_len  out  LEN_WIDTH  to CDMA
m_axis_desc_tag  out  M_TAG_WIDTH  {port index, port tag}
m_axis_desc_valid  out  1  to CDMA
m_axis_desc_ready  in  1  from CDMA
m_axis_desc_status_tag  in  M_TAG_WIDTH  from CDMA
m_axis_desc_status_valid  in  1  from CDMA, single-cycle strobe, no backpressure
enable  in  1  issue enable
outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight descriptor count
idle  out  1  no held descriptor and outstanding==0
status_error  out  1  sticky: status arrived while outstanding==0

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs 0, except idle=1.
  - Round-robin pointer (last granted) = PORTS-1, so port 0 has first priority.
- Output stage: one register slot (m_axis_desc_*), valid held with stable payload until m_axis_desc_ready.
- Slot can load when: (!m_axis_desc_valid || m_axis_desc_ready) && enable && outstanding_next_issue < MAX_OUTSTANDING.
  - outstanding_next_issue = outstanding + m_axis_desc_valid (counts the held descriptor).
- Grant:
  - When the slot can load, choose the first valid port searching from pointer+1 upward, wrapping modulo PORTS.
  - Combinationally assert s_axis_desc_ready for that port only; ready may depend on valid.
  - On that cycle the slot loads the payload, m_axis_desc_tag = {CL_PORTS'(i), tag_i}, and pointer <= i.
  - Latency: port valid to m_axis_desc_valid = 1 cycle.
- Outstanding counter:
  - +1 on m_axis_desc_valid && m_axis_desc_ready.
  - -1 on m_axis_desc_status_valid.
  - Both in the same cycle: unchanged.
  - Status while count==0 and no same-cycle issue: count stays 0, status_error <= 1 (cleared only by reset), status still routed.
- Status routing: on m_axis_desc_status_valid, port p = tag[M_TAG_WIDTH-1:S_TAG_WIDTH] and, registered next cycle:
  - s_axis_desc_status_valid[p] = 1 for one cycle;
  - s_axis_desc_status_tag[p] = tag[S_TAG_WIDTH-1:0];
  - other ports' tags hold their last value.
  - Port index >= PORTS (non-power-of-2 PORTS): dropped, status_error <= 1.
- Back-to-back status strobes are routed every cycle; no buffering is needed.
- enable low: no new grants. A held descriptor stays valid and may complete; status routing continues.
- Reset mid-operation: slot and counter cleared immediately; in-flight CDMA status arriving after reset release sets status_error.
- idle = !m_axis_desc_valid && outstanding==0 (registered).

Optional Feature:
Macro AXI_CDMA_DESC_ARB_ZERO_LEN_EN.
- Defined:
  - A granted descriptor with len==0 is not loaded into the slot and not counted.
  - Instead a local completion for that port is queued in a 1-entry pending register.
  - The pending completion is emitted on the next cycle with no CDMA status strobe.
  - While pending is full, zero-length descriptors are not granted; the port is skipped by arbitration that cycle.
- Undefined: len==0 is forwarded to the CDMA unchanged.

Decomposition:
- Package axi_cdma_arb_pkg holds:
  - port-index helper function;
  - tag pack/unpack functions ({port, tag});
  - status_error cause constants.
- One natural sub-module: rr_arbiter (PORTS-wide request vector, pointer register, one-hot grant, enable input), reusable elsewhere in the codebase.
- Counter, slot and status demux stay in the top module.

Test Plan:
- Single port 0 request (read 0x1000, write 0x2000, len 64, tag 0x5A) -> next cycle m_tag=0x05A, m_valid=1; CDMA status tag 0x05A -> port0 status_valid one cycle later with tag 0x5A; idle returns to 1.
- All 4 ports valid continuously, m_ready=1, status returned immediately -> grants in order 0,1,2,3,0,... with no port granted twice before the others.
- MAX_OUTSTANDING=8, no status returned -> exactly 8 descriptors accepted; s_ready stays 0 until one status arrives, then one more is accepted.
- Issue and status in the same cycle at outstanding=3 -> count stays 3; status with outstanding=0 -> status_error=1, count stays 0.
- enable dropped with a descriptor held and m_ready=0 -> m_valid stays 1 with payload stable; no new s_ready until enable=1.
- With AXI_CDMA_DESC_ARB_ZERO_LEN_EN: port2 len=0 tag 0x11 -> no m_valid; port2 status_valid with tag 0x11 within 2 cycles; outstanding unchanged.
